sm_dot_accumulator: RTL
=======================

// Module: sm_dot_accumulator
// PURPOSE
//  Consumes the 7-bit two's-complement products of the 4-bit sign-magnitude
//  multiplier stage, one per beat, and accumulates them into one signed dot
//  product per vector of up to VEC_LEN beats. Each finished sum is presented on a
//  valid/ready output towards the requantisation stage. Saturates instead of wrapping.
// PARAMETERS
//  VEC_LEN  16  max beats per vector (>=2); vector closes at VEC_LEN beats or in_last
//  ACC_W    11  accumulator/result width, signed; range +-(2^(ACC_W-1)-1)
//  CNT_W    $clog2(VEC_LEN+1)  width of out_count (derived localparam)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      prod/in_last valid
//  in_ready   out  1      block accepts beat this cycle
//  prod       in   7      signed product (two's complement, -64..63)
//  in_last    in   1      closes current vector early (beat included)
//  out_valid  out  1      out_sum/out_sat/out_count valid, held until taken
//  out_ready  in   1      downstream accepts result
//  out_sum    out  ACC_W  signed dot-product result
//  out_sat    out  1      saturation occurred anywhere in this vector
//  out_count  out  CNT_W  number of beats in this vector (1..VEC_LEN)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, acc=0, beat count=0, sat flag=0,
//   out_valid=0, out_sum=0, out_sat=0, out_count=0. in_ready=1 after release.
//  Accept = in_valid & in_ready; in_ready = !out_valid | out_ready (comb.).
//  FSM: IDLE (no partial sum) / ACC (partial sum held).
//   IDLE --accept, not closing--> ACC ; ACC --closing accept--> IDLE.
//   IDLE --closing accept (in_last on first beat)--> IDLE, vector length 1.
//  Closing beat: in_last=1, or beat count reaches VEC_LEN (in_last ignored then).
//  Sum: base = (state==IDLE) ? 0 : acc; s = base + sext(prod) at ACC_W+1 bits;
//   s > 2^(ACC_W-1)-1 -> clamp to max, s < -(2^(ACC_W-1)-1) -> clamp to -max,
//   set sticky sat flag. Most-negative code never produced.
//  On closing accept: out_sum<=clamped s, out_sat<=sat|this-beat-sat,
//   out_count<=beats incl. this one, out_valid<=1 next cycle (latency 1 cycle
//   from closing beat to out_valid); acc, count, sat cleared for next vector.
//  Non-closing accept: acc<=clamped s, count+1, out_* untouched.
//  out_valid & out_ready & no closing accept -> out_valid<=0 next cycle.
//  out_valid & out_ready & closing accept same cycle -> new result loaded,
//   out_valid stays 1 (zero bubble).
//  out_valid & !out_ready: in_ready=0, partial sum frozen, out_* stable.
//  in_valid=0 cycles: no state change; partial sums persist indefinitely.
//  prod=7'b1000000 (-64) accumulated as -64 though upstream never emits it.
//  Reset mid-vector discards partial sum and any pending result.
// TESTING
//  T1 16 beats prod=+49, out_ready=1 -> out_sum=784, out_sat=0, out_count=16,
//     out_valid one cycle after beat 16, exactly one cycle high.
//  T2 ACC_W=8, 4 beats +49 -> sums 49,98,127(sat),127; out_sum=127, out_sat=1;
//     repeat with -49 -> out_sum=-127, out_sat=1.
//  T3 beats +21,-35,+6 with in_last on 3rd -> out_sum=-8, out_count=3; then
//     single beat -7 with in_last -> out_sum=-7, out_count=1, acc not carried.
//  T4 out_ready=0 while a result is pending, in_valid=1 -> in_ready=0, out_*
//     stable 10 cycles; raise out_ready -> closing beat accepted same cycle,
//     out_valid stays 1 with new sum.
//  T5 assert rst_n=0 after 5 beats of +7 -> all outputs 0 asynchronously; next
//     vector of 2 beats +3,+4 (in_last) -> out_sum=7, out_count=2.
//  T6 random prod/in_valid/out_ready/in_last 10k beats vs golden model with
//     clamping; check no result lost or duplicated.

Source files
------------

// File: rtl/sm_dot_accumulator.sv
// Saturating signed dot-product accumulator: sums 7-bit products per vector
// (up to VEC_LEN beats or in_last) and hands each result out on valid/ready.
module sm_dot_accumulator #(
   parameter int unsigned VEC_LEN = 16,
   parameter int unsigned ACC_W   = 11,
   localparam int unsigned CNT_W  = $clog2(VEC_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       prod,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_sat,
   output logic [CNT_W-1:0] out_count
);

   localparam int unsigned SUM_W = ACC_W + 1;
   localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'((1 << (ACC_W - 1)) - 1);
   localparam logic signed [SUM_W-1:0] SUM_MIN = -SUM_MAX;
   localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'((1 << (ACC_W - 1)) - 1);
   localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(0) - ACC_MAX;

   typedef enum logic {
      ST_IDLE,
      ST_ACC
   } state_e;

   state_e             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sat_q, sat_d;
   logic               out_valid_q, out_valid_d;
   logic [ACC_W-1:0]   out_sum_q, out_sum_d;
   logic               out_sat_q, out_sat_d;
   logic [CNT_W-1:0]   out_count_q, out_count_d;

   logic               accept;
   logic signed [SUM_W-1:0] base;
   logic signed [SUM_W-1:0] sum_raw;
   logic [ACC_W-1:0]   sum_clamp;
   logic               beat_sat;
   logic [CNT_W-1:0]   beats;
   logic               closing;

   assign in_ready  = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_sat   = out_sat_q;
   assign out_count = out_count_q;

   // One extra bit of headroom so the overflow can be seen before clamping.
   always_comb begin
      base      = (state_q == ST_IDLE) ? '0 : {acc_q[ACC_W-1], acc_q};
      sum_raw   = base + {{(SUM_W - 7){prod[6]}}, prod};
      sum_clamp = sum_raw[ACC_W-1:0];
      beat_sat  = 1'b0;
      if (sum_raw > SUM_MAX) begin
         sum_clamp = ACC_MAX;
         beat_sat  = 1'b1;
      end else if (sum_raw < SUM_MIN) begin
         sum_clamp = ACC_MIN;
         beat_sat  = 1'b1;
      end
      beats   = cnt_q + CNT_W'(1);
      closing = in_last || (beats == CNT_W'(VEC_LEN));
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      sat_d       = sat_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_sat_d   = out_sat_q;
      out_count_d = out_count_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         if (closing) begin
            // Closing beat may reload the output in the same cycle it drains.
            out_valid_d = 1'b1;
            out_sum_d   = sum_clamp;
            out_sat_d   = sat_q || beat_sat;
            out_count_d = beats;
            acc_d       = '0;
            cnt_d       = '0;
            sat_d       = 1'b0;
            state_d     = ST_IDLE;
         end else begin
            acc_d   = sum_clamp;
            cnt_d   = beats;
            sat_d   = sat_q || beat_sat;
            state_d = ST_ACC;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_sat_q   <= 1'b0;
         out_count_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sat_q       <= sat_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_sat_q   <= out_sat_d;
         out_count_q <= out_count_d;
      end
   end

endmodule
